// File: rtl/mux21_rr_ctrl.sv
// Round-robin arbiter and sequencer for two producer lanes feeding a 2:1 valid-qualified mux.
// Grants are combinational (zero latency); a burst counter limits consecutive grants to one lane.
module mux21_rr_ctrl #(
   parameter int BURST_MAX = 4,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_valid,
   input  logic             in1_valid,
   input  logic             hold,
   output logic             select,
   output logic             pop0,
   output logic             pop1,
   output logic             busy,
   output logic [CNT_W-1:0] burst_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             last_q;
   logic             sel_q;
   logic             busy_q;

   logic             gnt_vld_d;
   logic             gnt_lane_d;
   logic             burst_done_d;
   logic             same_owner_d;
   logic [CNT_W-1:0] cnt_d;

   assign burst_done_d = (cnt_q >= BURST_LIM);

   // Grant decision; reset and hold both suppress any pop in the current cycle.
   always_comb begin
      gnt_vld_d  = 1'b0;
      gnt_lane_d = 1'b0;
      if (!reset && !hold) begin
         if (in0_valid && !in1_valid) begin
            gnt_vld_d  = 1'b1;
            gnt_lane_d = 1'b0;
         end else if (in1_valid && !in0_valid) begin
            gnt_vld_d  = 1'b1;
            gnt_lane_d = 1'b1;
         end else if (in0_valid && in1_valid) begin
            gnt_vld_d = 1'b1;
            case (state_q)
               OWN0:    gnt_lane_d = burst_done_d;
               OWN1:    gnt_lane_d = !burst_done_d;
               default: gnt_lane_d = !last_q;
            endcase
         end
      end
   end

   // Burst count restarts at 1 on an owner change and saturates at the limit otherwise.
   always_comb begin
      same_owner_d = (gnt_lane_d  && (state_q == OWN1)) ||
                     (!gnt_lane_d && (state_q == OWN0));
      cnt_d = CNT_ONE;
      if (same_owner_d) begin
         cnt_d = (cnt_q >= BURST_LIM) ? BURST_LIM : (cnt_q + CNT_ONE);
      end
   end

   assign select    = reset ? 1'b0 : (gnt_vld_d ? gnt_lane_d : sel_q);
   assign pop0      = gnt_vld_d && !gnt_lane_d;
   assign pop1      = gnt_vld_d && gnt_lane_d;
   assign busy      = busy_q;
   assign burst_cnt = cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else if (hold) begin
         state_q <= state_q;
         cnt_q   <= cnt_q;
         last_q  <= last_q;
         sel_q   <= sel_q;
         busy_q  <= busy_q;
      end else if (gnt_vld_d) begin
         state_q <= gnt_lane_d ? OWN1 : OWN0;
         cnt_q   <= cnt_d;
         last_q  <= gnt_lane_d;
         sel_q   <= gnt_lane_d;
         busy_q  <= 1'b1;
      end else begin
         // Nobody requesting: drop back to IDLE but remember who was served last.
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux21_rr_ctrl.sv
// Scoreboard bench for mux21_rr_ctrl: directed vectors push expected outputs, a monitor pops and compares.
module tb_mux21_rr_ctrl;

   logic       clk;
   logic       reset;
   logic       in0_valid;
   logic       in1_valid;
   logic       hold;
   logic       select;
   logic       pop0;
   logic       pop1;
   logic       busy;
   logic [2:0] burst_cnt;

   typedef struct packed {
      logic       rst;
      logic       i0;
      logic       i1;
      logic       hld;
      logic       p0;
      logic       p1;
      logic       sel;
      logic [2:0] cnt;
      logic       bsy;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   idx_q[$];
   int   n_checks;
   int   n_pass;

   mux21_rr_ctrl #(.BURST_MAX(4), .CNT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in0_valid (in0_valid),
      .in1_valid (in1_valid),
      .hold      (hold),
      .select    (select),
      .pop0      (pop0),
      .pop1      (pop1),
      .busy      (busy),
      .burst_cnt (burst_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs for the cycle, then expected pop0/pop1/select for that cycle and the
   // burst_cnt/busy visible during it (registered by the previous edge).
   task automatic add(input logic r, input logic a, input logic b, input logic h,
                      input logic ep0, input logic ep1, input logic es,
                      input int ec, input logic eb);
      vec_t v;
      v.rst = r; v.i0 = a; v.i1 = b; v.hld = h;
      v.p0 = ep0; v.p1 = ep1; v.sel = es; v.cnt = 3'(ec); v.bsy = eb;
      vecs.push_back(v);
   endtask

   // Monitor: compare DUT outputs mid-cycle against the scoreboard head.
   initial begin
      vec_t e;
      int   k;
      logic [6:0] got;
      logic [6:0] req;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            k   = idx_q.pop_front();
            got = {pop0, pop1, select, burst_cnt, busy};
            req = {e.p0, e.p1, e.sel, e.cnt, e.bsy};
            n_checks++;
            if (got === req) n_pass++;
            else $display("FAIL vec%0d {pop0,pop1,sel,cnt,busy}: got %b_%b_%b_%0d_%b required %b_%b_%b_%0d_%b",
                          k, pop0, pop1, select, burst_cnt, busy,
                          e.p0, e.p1, e.sel, e.cnt, e.bsy);
         end
      end
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b1;
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      hold      = 1'b0;

      // Reset with both lanes requesting, then first grant to lane 0
      add(1,1,1,0, 0,0,0, 0,0);
      add(1,1,1,0, 0,0,0, 0,0);
      add(0,1,1,0, 1,0,0, 0,0);
      // Continuous contention, BURST_MAX=4
      add(0,1,1,0, 1,0,0, 1,1);
      add(0,1,1,0, 1,0,0, 2,1);
      add(0,1,1,0, 1,0,0, 3,1);
      add(0,1,1,0, 0,1,1, 4,1);
      add(0,1,1,0, 0,1,1, 1,1);
      add(0,1,1,0, 0,1,1, 2,1);
      add(0,1,1,0, 0,1,1, 3,1);
      add(0,1,1,0, 1,0,0, 4,1);
      add(0,1,1,0, 1,0,0, 1,1);
      add(0,1,1,0, 1,0,0, 2,1);
      add(0,1,1,0, 1,0,0, 3,1);
      add(0,1,1,0, 0,1,1, 4,1);
      add(0,1,1,0, 0,1,1, 1,1);
      add(0,1,1,0, 0,1,1, 2,1);
      add(0,1,1,0, 0,1,1, 3,1);
      // Idle gap keeps select, then lane 1 alone saturates the counter
      add(0,0,0,0, 0,0,1, 4,1);
      add(0,0,1,0, 0,1,1, 0,0);
      add(0,0,1,0, 0,1,1, 1,1);
      add(0,0,1,0, 0,1,1, 2,1);
      add(0,0,1,0, 0,1,1, 3,1);
      add(0,0,1,0, 0,1,1, 4,1);
      add(0,0,1,0, 0,1,1, 4,1);
      add(0,0,1,0, 0,1,1, 4,1);
      add(0,0,1,0, 0,1,1, 4,1);
      add(0,1,1,0, 1,0,0, 4,1);
      // Hold at OWN0 with count 2
      add(0,1,1,0, 1,0,0, 1,1);
      add(0,1,1,1, 0,0,0, 2,1);
      add(0,1,1,1, 0,0,0, 2,1);
      add(0,1,1,1, 0,0,0, 2,1);
      add(0,1,1,0, 1,0,0, 2,1);
      add(0,1,1,0, 1,0,0, 3,1);
      add(0,1,1,0, 0,1,1, 4,1);
      // One-cycle gap after serving lane 1
      add(0,0,0,0, 0,0,1, 1,1);
      add(0,1,1,0, 1,0,0, 0,0);
      add(0,1,1,0, 1,0,0, 1,1);
      // Reset pulse at OWN1 with count 2
      add(0,0,1,0, 0,1,1, 2,1);
      add(0,0,1,0, 0,1,1, 1,1);
      add(1,1,1,0, 0,0,0, 2,1);
      add(0,1,1,0, 1,0,0, 0,0);
      add(0,1,1,0, 1,0,0, 1,1);
      // Hold while idle keeps the FSM in IDLE
      add(0,0,0,0, 0,0,0, 2,1);
      add(0,1,1,1, 0,0,0, 0,0);
      add(0,0,0,0, 0,0,0, 0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         reset     = vecs[i].rst;
         in0_valid = vecs[i].i0;
         in1_valid = vecs[i].i1;
         hold      = vecs[i].hld;
         exp_q.push_back(vecs[i]);
         idx_q.push_back(i);
      end
      @(posedge clk);
      #1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux21_rr_ctrl.md
# mux21_rr_ctrl

Round-robin arbiter and sequencer for the 2:1 valid-qualified 4-bit mux (`mux21_4b`). It sits in front of the mux and decides each cycle which of two producer lanes owns the mux. It drives the mux `select` and issues per-lane pop strobes. The mux valid inputs are fed from the pops, so exactly one word per grant reaches `out_b`/`out_valid_b`. A burst limit stops one lane from starving the other, and a `hold` input freezes arbitration when downstream stalls.

## Interface
- `BURST_MAX`, default 4: maximum consecutive grants to one lane while the other lane is requesting. Legal range 1..2^CNT_W-1.
- `CNT_W`, default 3: width of the burst counter.

- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `in0_valid`  in  1  lane 0 has a word available.
- `in1_valid`  in  1  lane 1 has a word available.
- `hold`  in  1  downstream stall. While high: no grant, state frozen.
- `select`  out  1  mux select, 0 = lane 0, 1 = lane 1. Connects to mux `select`.
- `pop0`  out  1  lane 0 granted and consumed this cycle. Connects to mux `in0_valid` and lane 0 dequeue.
- `pop1`  out  1  lane 1 granted this cycle. Connects to mux `in1_valid` and lane 1 dequeue.
- `busy`  out  1  registered; 1 when the FSM is not in IDLE.
- `burst_cnt`  out  CNT_W  registered consecutive-grant count for the current owner (debug/verification).

## Operation
- Registered state:
  - FSM `{IDLE, OWN0, OWN1}`.
  - `burst_cnt`.
  - `last` (last served lane).
  - `sel_q` (held select).
- Grant decision is combinational from state, `in0_valid`, `in1_valid` and `hold`. At most one of `pop0`/`pop1` is high in any cycle.
- `hold`=1: `pop0`=`pop1`=0, `select`=`sel_q`, and all registers keep their values.
- `hold`=0, no valid: no pop, `select`=`sel_q`. Next state is IDLE with `burst_cnt`=0; `last` and `sel_q` are retained.
- `hold`=0, exactly one valid: that lane is granted regardless of state or count.
- `hold`=0, both valid:
  - IDLE: grant lane != `last`.
  - OWNx with `burst_cnt` < BURST_MAX: grant lane x (continue burst).
  - OWNx with `burst_cnt` >= BURST_MAX: grant the other lane.
- On a grant to lane g:
  - `select`=g in the same cycle, `pop_g`=1.
  - Next state OWNg, `last`=g, `sel_q`=g.
  - `burst_cnt` next = 1 if the previous state was not OWNg; otherwise `burst_cnt`+1, saturating at BURST_MAX.
- `busy` = (state != IDLE).
- BURST_MAX=1 gives strict alternation whenever both lanes request.
- `burst_cnt` never exceeds BURST_MAX; there is no wrap-around.

## Timing
- Reset values:
  - state IDLE, `burst_cnt`=0, `last`=1, `sel_q`=0.
  - While `reset` is high, `pop0`=`pop1`=0 and `select`=0, regardless of inputs.
  - `busy`=0 in the cycle after reset.
- First arbitration after reset with both lanes valid goes to lane 0.
- Grant latency is zero: pop and `select` respond combinationally in the same cycle as valid.
- The mux registers the data, so the word popped in cycle N appears on `out_b` with `out_valid_b`=1 in cycle N+1.
- Reset asserted mid-burst: at the next edge, state is IDLE, `burst_cnt`=0, `last`=1. Any pending burst is discarded; no pop occurs in the reset cycle.
- `hold` rising in the same cycle as valid: `hold` wins and no pop occurs. On release, arbitration resumes from the frozen `burst_cnt`/owner.
- `hold` asserted during IDLE keeps the FSM in IDLE.

## Test plan
1. Assert `reset` for 2 cycles with `in0_valid`=`in1_valid`=1, then release. Required:
   - no pop during reset;
   - first post-reset cycle `pop0`=1, `select`=0, `burst_cnt`→1;
   - `out_valid_b`=1 with lane-0 data one cycle later.
2. BURST_MAX=4, both lanes valid continuously for 16 cycles. Required:
   - grant sequence 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1;
   - `burst_cnt` sequence 1,2,3,4 repeating;
   - never both pops high.
3. Only `in1_valid` high for 8 cycles. Required:
   - `pop1` every cycle and `burst_cnt` saturates at 4.
   - Then raise `in0_valid`: next cycle `pop0`=1, `select`=0, `burst_cnt`=1.
4. Both lanes valid; at OWN0 with `burst_cnt`=2, assert `hold` for 3 cycles. Required:
   - no pops, `select` stays 0, `burst_cnt` stays 2;
   - after release, lane 0 is granted 2 more cycles (cnt 3,4), then lane 1.
5. Serve lane 1 (`last`=1), drop both valids for 1 cycle, then raise both. Required:
   - `busy`=0 after the gap;
   - grant goes to lane 0 with `burst_cnt`=1.
6. Pulse `reset` for 1 cycle at OWN1 with `burst_cnt`=2 and both valids high. Required:
   - reset cycle pops 0;
   - next cycle `pop0`=1, `select`=0, `burst_cnt`=1.
